regfile_dump: RTL and testbench
===============================

# regfile_dump

Read-side companion to the 4×8 register file. On a `start` pulse it walks the register file's read port over every register and serialises the contents onto a valid/ready byte stream as a framed dump: header, one byte per register, then an XOR checksum. It sits between the register file and the debug/host byte link (UART TX or test bench sink). It never writes the register file.

## Interface
- `NUM_REGS`, default 4: registers dumped per frame, read from address 0 upward.
- `ADDR_W`, default 2: register address width; `NUM_REGS` ≤ 2^`ADDR_W`.
- `DATA_W`, default 8: register and stream byte width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state and outputs on the next rising edge.
- `start` in 1: request a dump; sampled only in IDLE.
- `rd_addr` out `ADDR_W`: drives a register-file read address (`read_register1` or `read_register2`).
- `rd_data` in `DATA_W`: matching combinational read data from the register file.
- `out_valid` out 1: stream byte valid.
- `out_ready` in 1: sink accepts the byte when `out_valid && out_ready` at a rising edge.
- `out_data` out `DATA_W`: stream byte.
- `out_last` out 1: marks the checksum byte, the final byte of the frame.
- `busy` out 1: high from the cycle after `start` is accepted until DONE exits.
- `done` out 1: one-cycle pulse after the checksum byte is accepted.

## Operation
- States: IDLE, HDR, FETCH, SEND, SUM, DONE.
- IDLE: `busy`=0, `out_valid`=0. If `start`=1: `idx`←0, `csum`←0, go to HDR.
- HDR: `out_valid`=1, `out_data`=`HDR_BYTE` (8'hA5). Go to FETCH on accept.
- FETCH: `rd_addr`=`idx`. `rd_data` is captured into the output data register at the end of this cycle. Go to SEND. Lasts exactly one cycle.
- SEND: `out_valid`=1, `out_data`=captured byte. On accept: `csum`←`csum` ^ `out_data`. If `idx`==`NUM_REGS`-1, go to SUM; otherwise `idx`←`idx`+1 and go to FETCH.
- SUM: `out_valid`=1, `out_data`=`csum`, `out_last`=1. Go to DONE on accept.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `rd_addr` equals `idx` at all times. It is valid for reading only in FETCH.
- Checksum is the XOR of the `NUM_REGS` data bytes only. The header is excluded.
- Snapshot semantics: each register's value is fixed at its FETCH cycle. Later register-file writes do not alter the frame.
- `start` asserted outside IDLE is ignored. It is not queued.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, `rd_addr`=0, state=IDLE.
- Reset mid-frame aborts the frame. Outputs take their reset values on the next edge and no `done` is produced.
- With `out_ready` held high and `start` in cycle 0:
  - HDR is in cycle 1.
  - FETCH/SEND pairs occupy cycles 2–9.
  - SUM is in cycle 10.
  - `done` is in cycle 11.
  - IDLE is in cycle 12, and a new `start` is accepted in cycle 12.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_last` hold stable and the state holds.
- `out_valid` never drops without an accept, except on reset.
- All stream outputs are registered. No combinational path runs from `out_ready` to `out_valid` or `out_data`.

## Structure
- `regfile_dump_pkg` holds:
  - the state enum;
  - `HDR_BYTE` = 8'hA5;
  - the default `NUM_REGS`, `ADDR_W` and `DATA_W` constants, shared with the register file.
- Single module. The FSM, `idx` counter, `csum` accumulator and output register are all inline; no sub-module is warranted.

## Test plan
- Registers = 11,22,44,88 (hex), `out_ready`=1, pulse `start` → stream A5,11,22,44,88,FF with `out_last` only on FF, and `done` in cycle 11.
- All registers = 00 → stream A5,00,00,00,00,00; `busy` falls after `done`.
- Same data as the first case, `out_ready` toggling 1-0-1-0 → identical byte sequence; each byte is held stable while stalled; no byte is dropped or duplicated.
- Write reg0←7F after its SEND is accepted but mid-frame → frame carries the old reg0 value. A second dump then carries 7F.
- Pulse `start` during SEND → ignored; exactly one frame is produced.
- Assert `reset` during the third data byte → `out_valid`=0 next cycle, no `done`. A fresh `start` then yields a complete frame from the header onward.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump block.
// The size defaults match the companion 4x8 register file.
package regfile_dump_pkg;

  localparam int unsigned NUM_REGS_DEF = 4;
  localparam int unsigned ADDR_W_DEF   = 2;
  localparam int unsigned DATA_W_DEF   = 8;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_SEND,
    ST_SUM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks the register-file read port and emits a framed dump on a valid/ready
// byte stream: header, one byte per register, then the XOR checksum.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] csum;

  assign rd_addr = idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      csum      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= '0;
            csum      <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= DATA_W'(HDR_BYTE);
            out_last  <= 1'b0;
            state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            csum <= csum ^ out_data;
            if (idx == LAST_IDX) begin
              // Checksum byte is loaded straight behind the last data byte,
              // so out_valid stays high across the SEND->SUM boundary.
              out_data <= csum ^ out_data;
              out_last <= 1'b1;
              state    <= ST_SUM;
            end else begin
              idx       <= idx + ADDR_W'(1);
              out_valid <= 1'b0;
              state     <= ST_FETCH;
            end
          end
        end
        ST_SUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural 4x8 register file.
module tb_regfile_dump;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] regs [4];

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  regfile_dump #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // per-frame knobs and capture
  int         cyc;
  int         ready_mode;
  int         wr_cyc;
  int         st2_cyc;
  int         rst_cyc;
  logic [7:0] got_data [$];
  logic       got_last [$];
  int         done_cnt;
  int         done_cyc;
  logic       busy_hist  [64];
  logic       valid_hist [64];

  task automatic tick();
    logic       stalled;
    logic [7:0] sd;
    logic       sl;
    start     = (cyc == 0) || (cyc == st2_cyc);
    reset     = (cyc == rst_cyc);
    out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 2 == 0);
    if (cyc == wr_cyc) regs[0] = 8'h7F;
    #1;
    busy_hist[cyc]  = busy;
    valid_hist[cyc] = out_valid;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_valid && out_ready && !reset) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
    stalled = out_valid && !out_ready && !reset;
    sd = out_data;
    sl = out_last;
    @(posedge clk);
    #1;
    cyc++;
    if (stalled) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(sd));
      chk("stall_last", 32'(out_last), 32'(sl));
    end
  endtask

  task automatic run_frame(input int mode, input int wr, input int st2, input int rst);
    ready_mode = mode;
    wr_cyc     = wr;
    st2_cyc    = st2;
    rst_cyc    = rst;
    cyc        = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    got_data.delete();
    got_last.delete();
    for (int i = 0; i < 40; i++) tick();
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp [6], input int n);
    chk({tag, "_count"}, 32'(got_data.size()), 32'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_data[i]), 32'(exp[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), (i == 5) ? 32'd1 : 32'd0);
    end
  endtask

  typedef struct {
    logic [7:0] r [4];
    int         mode;
    logic [7:0] csum;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] exp [6];

  initial begin
    vecs[0] = '{r: '{8'h11, 8'h22, 8'h44, 8'h88}, mode: 0, csum: 8'hFF};
    vecs[1] = '{r: '{8'h00, 8'h00, 8'h00, 8'h00}, mode: 0, csum: 8'h00};
    vecs[2] = '{r: '{8'h11, 8'h22, 8'h44, 8'h88}, mode: 1, csum: 8'hFF};
    vecs[3] = '{r: '{8'hA5, 8'hFF, 8'h00, 8'h3C}, mode: 0, csum: 8'h66};
    vecs[4] = '{r: '{8'h01, 8'h02, 8'h04, 8'h08}, mode: 1, csum: 8'h0F};

    regs      = '{8'h00, 8'h00, 8'h00, 8'h00};
    start     = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      regs = vecs[v].r;
      exp  = '{8'hA5, vecs[v].r[0], vecs[v].r[1], vecs[v].r[2], vecs[v].r[3], vecs[v].csum};
      run_frame(vecs[v].mode, -1, -1, -1);
      check_frame($sformatf("vec%0d", v), exp, 6);
      chk($sformatf("vec%0d_done_cnt", v), 32'(done_cnt), 32'd1);
      if (vecs[v].mode == 0) begin
        chk($sformatf("vec%0d_done_cyc", v), 32'(done_cyc), 32'd11);
        chk($sformatf("vec%0d_busy1", v), 32'(busy_hist[1]), 32'd1);
        chk($sformatf("vec%0d_busy11", v), 32'(busy_hist[11]), 32'd1);
        chk($sformatf("vec%0d_busy12", v), 32'(busy_hist[12]), 32'd0);
      end
    end

    // reg0 rewritten after its byte went out: frame keeps the old value
    regs = '{8'h11, 8'h22, 8'h44, 8'h88};
    exp  = '{8'hA5, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF};
    run_frame(0, 4, -1, -1);
    check_frame("snap1", exp, 6);
    exp  = '{8'hA5, 8'h7F, 8'h22, 8'h44, 8'h88, 8'h91};
    run_frame(0, -1, -1, -1);
    check_frame("snap2", exp, 6);

    // second start while in SEND of reg1 must be ignored
    regs = '{8'h11, 8'h22, 8'h44, 8'h88};
    exp  = '{8'hA5, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF};
    run_frame(0, -1, 5, -1);
    check_frame("ign", exp, 6);
    chk("ign_done_cnt", 32'(done_cnt), 32'd1);

    // reset during the third data byte (SEND of reg2 in cycle 7)
    exp = '{8'hA5, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    run_frame(0, -1, -1, 7);
    check_frame("rst", exp, 3);
    chk("rst_valid_c7", 32'(valid_hist[7]), 32'd1);
    chk("rst_valid_c8", 32'(valid_hist[8]), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_busy_c8", 32'(busy_hist[8]), 32'd0);
    exp = '{8'hA5, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF};
    run_frame(0, -1, -1, -1);
    check_frame("post", exp, 6);
    chk("post_done_cyc", 32'(done_cyc), 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
